arbiter_1_to_n_response_router: RTL and testbench

- Parametrised successor to the two-way cache response splitter: one cache-response stream is buffered in an ingress FIFO, then routed to any of NUM_MEMORY_REQUESTOR requestors by a destination field carried with each response.
- Adds per-lane ready backpressure, a broadcast mode, counted drops for unroutable responses, and an overflow flag.
- Sits between the cache response port and the CU/bundle response consumers.

---
 rtl/arbiter_1_to_n_response_router.sv | 234 +++++++++++++++++++++++
 tb/tb_arbiter_1_to_n_response_router.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_1_to_n_response_router.sv
// ---------------------------------------------------------------------------
// arbiter_1_to_n_response_router
//
// Buffers a single cache-response stream in an ingress FIFO and routes each
// response to one of NUM_MEMORY_REQUESTOR lanes using the destination field
// that travels with it. An all-ones destination broadcasts to every lane
// when BROADCAST_EN is set. Unroutable heads are dropped and counted.
//
// Ports:
//   ap_clk                clock, rising edge
//   areset                synchronous active-high reset
//   response_in_valid     input response valid
//   response_in_payload   input response data
//   response_in_dest      destination lane, all-ones = broadcast
//   response_out_valid    per-lane valid (pending lane mask)
//   response_out_payload  payload shared by all lanes
//   response_out_ready    per-lane accept
//   fifo_full             occupancy == depth (registered)
//   fifo_empty            occupancy == 0 (registered)
//   fifo_prog_full        occupancy >= PROG_THRESH (registered)
//   fifo_overflow         sticky: a write was lost because the FIFO was full
//   drop_count            saturating count of unroutable responses
//   fifo_setup_signal     high while the block is not yet accepting input
// ---------------------------------------------------------------------------
module arbiter_1_to_n_response_router #(
  parameter int NUM_MEMORY_REQUESTOR = 4,
  parameter int ID_W                 = 4,
  parameter int PAYLOAD_W            = 128,
  parameter int FIFO_ARBITER_DEPTH   = 16,
  parameter int PROG_THRESH          = FIFO_ARBITER_DEPTH - 4,
  parameter bit BROADCAST_EN         = 1'b1,
  parameter int SETUP_CYCLES         = 4
) (
  input  logic                            ap_clk,
  input  logic                            areset,
  input  logic                            response_in_valid,
  input  logic [PAYLOAD_W-1:0]            response_in_payload,
  input  logic [ID_W-1:0]                 response_in_dest,
  output logic [NUM_MEMORY_REQUESTOR-1:0] response_out_valid,
  output logic [PAYLOAD_W-1:0]            response_out_payload,
  input  logic [NUM_MEMORY_REQUESTOR-1:0] response_out_ready,
  output logic                            fifo_full,
  output logic                            fifo_empty,
  output logic                            fifo_prog_full,
  output logic                            fifo_overflow,
  output logic [15:0]                     drop_count,
  output logic                            fifo_setup_signal
);

  localparam int N      = NUM_MEMORY_REQUESTOR;
  localparam int PTR_W  = $clog2(FIFO_ARBITER_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SCNT_W = $clog2(SETUP_CYCLES + 1);
  localparam int ENT_W  = PAYLOAD_W + ID_W;
  localparam logic [N-1:0]     ONE_LANE = N'(1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_ARBITER_DEPTH);
  localparam logic [CNT_W-1:0] PROG_C   = CNT_W'(PROG_THRESH);

  typedef enum logic {CTL_SETUP, CTL_RUN} ctl_state_e;
  typedef enum logic {OUT_IDLE, OUT_HOLD} out_state_e;

  ctl_state_e              ctl_state_q, ctl_state_d;
  logic [SCNT_W-1:0]       setup_cnt_q, setup_cnt_d;
  out_state_e              out_state_q, out_state_d;

  logic                    in_valid_q;
  logic [PAYLOAD_W-1:0]    in_payload_q;
  logic [ID_W-1:0]         in_dest_q;

  logic [ENT_W-1:0]        mem_q [FIFO_ARBITER_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        count_q, count_d;

  logic [N-1:0]            mask_q, mask_d;
  logic [PAYLOAD_W-1:0]    payload_q, payload_d;
  logic                    full_q, empty_q, prog_q, ovf_q;
  logic [15:0]             drop_q;

  logic [ENT_W-1:0]        head_entry;
  logic [PAYLOAD_W-1:0]    head_payload;
  logic [ID_W-1:0]         head_dest;
  logic [N-1:0]            head_mask;
  logic                    head_routable;
  logic                    head_valid;
  logic [N-1:0]            mask_rem;
  logic                    stage_free;
  logic                    pop_load, pop_drop, pop, push;

  assign head_entry   = mem_q[rd_ptr_q];
  assign head_payload = head_entry[ENT_W-1:ID_W];
  assign head_dest    = head_entry[ID_W-1:0];
  assign head_valid   = (count_q != '0);

  // Lanes still waiting after this cycle's handshakes; the stage can take a
  // new head as soon as this is empty, which gives bubble-free delivery.
  assign mask_rem   = mask_q & ~response_out_ready;
  assign stage_free = (mask_rem == '0);
  assign pop_load   = head_valid & head_routable & stage_free;
  assign pop_drop   = head_valid & ~head_routable;
  assign pop        = pop_load | pop_drop;
  assign push       = in_valid_q & ((count_q != DEPTH_C) | pop);

  // Head destination decode into a lane mask.
  always_comb begin
    head_mask     = '0;
    head_routable = 1'b0;
    if (head_dest < ID_W'(N)) begin
      head_mask     = ONE_LANE << head_dest;
      head_routable = 1'b1;
    end else if ((BROADCAST_EN == 1'b1) && (head_dest == {ID_W{1'b1}})) begin
      head_mask     = '1;
      head_routable = 1'b1;
    end else begin
      head_mask     = '0;
      head_routable = 1'b0;
    end
  end

  // Control FSM: hold off input for SETUP_CYCLES cycles after reset.
  always_comb begin
    ctl_state_d = ctl_state_q;
    setup_cnt_d = setup_cnt_q;
    case (ctl_state_q)
      CTL_SETUP: begin
        if (setup_cnt_q == SCNT_W'(SETUP_CYCLES - 1)) begin
          ctl_state_d = CTL_RUN;
        end else begin
          setup_cnt_d = setup_cnt_q + SCNT_W'(1);
        end
      end
      CTL_RUN: ctl_state_d = CTL_RUN;
      default: ctl_state_d = CTL_SETUP;
    endcase
  end

  // Output stage FSM: holds one response and its pending lane mask.
  always_comb begin
    out_state_d = out_state_q;
    mask_d      = mask_rem;
    payload_d   = payload_q;
    case (out_state_q)
      OUT_IDLE, OUT_HOLD: begin
        if (pop_load) begin
          mask_d      = head_mask;
          payload_d   = head_payload;
          out_state_d = OUT_HOLD;
        end else if (stage_free) begin
          out_state_d = OUT_IDLE;
        end else begin
          out_state_d = OUT_HOLD;
        end
      end
      default: begin
        mask_d      = '0;
        out_state_d = OUT_IDLE;
      end
    endcase
  end

  // Occupancy next state; push and pop together leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge ap_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_payload_q, in_dest_q};
    end
  end

  // All control state, pointers, flags and the output stage.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      ctl_state_q  <= CTL_SETUP;
      setup_cnt_q  <= '0;
      out_state_q  <= OUT_IDLE;
      in_valid_q   <= 1'b0;
      in_payload_q <= '0;
      in_dest_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      mask_q       <= '0;
      payload_q    <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      prog_q       <= 1'b0;
      ovf_q        <= 1'b0;
      drop_q       <= 16'h0000;
    end else begin
      ctl_state_q  <= ctl_state_d;
      setup_cnt_q  <= setup_cnt_d;
      out_state_q  <= out_state_d;
      // Inputs arriving during SETUP never reach the input register.
      in_valid_q   <= response_in_valid & (ctl_state_q == CTL_RUN);
      in_payload_q <= response_in_payload;
      in_dest_q    <= response_in_dest;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q      <= count_d;
      mask_q       <= mask_d;
      payload_q    <= payload_d;
      full_q       <= (count_d == DEPTH_C);
      empty_q      <= (count_d == '0);
      prog_q       <= (count_d >= PROG_C);
      if (in_valid_q && !push) begin
        ovf_q <= 1'b1;
      end
      if (pop_drop && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'h0001;
      end
    end
  end

  assign response_out_valid   = mask_q;
  assign response_out_payload = payload_q;
  assign fifo_full            = full_q;
  assign fifo_empty           = empty_q;
  assign fifo_prog_full       = prog_q;
  assign fifo_overflow        = ovf_q;
  assign drop_count           = drop_q;
  assign fifo_setup_signal    = (ctl_state_q == CTL_SETUP);

endmodule

// File: tb/tb_arbiter_1_to_n_response_router.sv
// ---------------------------------------------------------------------------
// Directed bench for arbiter_1_to_n_response_router. Inputs are driven 1 time
// unit after each rising edge and outputs are sampled at the same point,
// before the next stimulus is applied. A second instance with broadcast
// disabled shares all inputs; only its drop counter is examined.
// ---------------------------------------------------------------------------
module tb_arbiter_1_to_n_response_router;

  logic         ap_clk;
  logic         areset;
  logic         response_in_valid;
  logic [127:0] response_in_payload;
  logic [3:0]   response_in_dest;
  logic [3:0]   response_out_valid;
  logic [127:0] response_out_payload;
  logic [3:0]   response_out_ready;
  logic         fifo_full, fifo_empty, fifo_prog_full, fifo_overflow;
  logic [15:0]  drop_count;
  logic         fifo_setup_signal;

  logic [3:0]   nb_valid;
  logic [127:0] nb_payload;
  logic         nb_full, nb_empty, nb_prog, nb_ovf;
  logic [15:0]  nb_drop;
  logic         nb_setup;

  int total = 0;
  int bad   = 0;

  arbiter_1_to_n_response_router dut (
    .ap_clk(ap_clk), .areset(areset),
    .response_in_valid(response_in_valid),
    .response_in_payload(response_in_payload),
    .response_in_dest(response_in_dest),
    .response_out_valid(response_out_valid),
    .response_out_payload(response_out_payload),
    .response_out_ready(response_out_ready),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_prog_full(fifo_prog_full), .fifo_overflow(fifo_overflow),
    .drop_count(drop_count), .fifo_setup_signal(fifo_setup_signal)
  );

  arbiter_1_to_n_response_router #(.BROADCAST_EN(1'b0)) dut_nb (
    .ap_clk(ap_clk), .areset(areset),
    .response_in_valid(response_in_valid),
    .response_in_payload(response_in_payload),
    .response_in_dest(response_in_dest),
    .response_out_valid(nb_valid),
    .response_out_payload(nb_payload),
    .response_out_ready(response_out_ready),
    .fifo_full(nb_full), .fifo_empty(nb_empty),
    .fifo_prog_full(nb_prog), .fifo_overflow(nb_ovf),
    .drop_count(nb_drop), .fifo_setup_signal(nb_setup)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] d, input logic [127:0] p);
    response_in_valid   = 1'b1;
    response_in_dest    = d;
    response_in_payload = p;
  endtask

  task automatic idle_in();
    response_in_valid = 1'b0;
  endtask

  initial begin
    int cnt;
    areset              = 1'b1;
    response_in_valid   = 1'b0;
    response_in_payload = '0;
    response_in_dest    = '0;
    response_out_ready  = 4'b0000;
    repeat (3) step();

    // Reset values
    check("rst_valid",   128'(response_out_valid),   128'(4'b0000));
    check("rst_payload", 128'(response_out_payload), 128'(0));
    check("rst_full",    128'(fifo_full),      128'(1'b0));
    check("rst_empty",   128'(fifo_empty),     128'(1'b1));
    check("rst_prog",    128'(fifo_prog_full), 128'(1'b0));
    check("rst_ovf",     128'(fifo_overflow),  128'(1'b0));
    check("rst_drop",    128'(drop_count),     128'(16'h0000));
    check("rst_setup",   128'(fifo_setup_signal), 128'(1'b1));

    // SETUP window: input is ignored
    areset = 1'b0;
    drive(4'd0, 128'h77);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("setup_sig_%0d", i), 128'(fifo_setup_signal), 128'(i < 4));
    end
    idle_in();
    for (int i = 0; i < 4; i++) begin
      step();
      check("setup_novalid", 128'(response_out_valid), 128'(4'b0000));
      check("setup_empty",   128'(fifo_empty), 128'(1'b1));
    end
    check("setup_drop", 128'(drop_count), 128'(16'h0000));

    // Unicast back-to-back, all lanes ready
    response_out_ready = 4'b1111;
    drive(4'd2, 128'hA5); step();
    drive(4'd0, 128'h10); step();
    check("uni_empty_e1", 128'(fifo_empty), 128'(1'b0));
    drive(4'd1, 128'h11); step();
    check("uni_v2", 128'(response_out_valid),   128'(4'b0100));
    check("uni_p2", 128'(response_out_payload), 128'hA5);
    drive(4'd3, 128'h13); step();
    check("uni_v0", 128'(response_out_valid),   128'(4'b0001));
    check("uni_p0", 128'(response_out_payload), 128'h10);
    idle_in(); step();
    check("uni_v1", 128'(response_out_valid),   128'(4'b0010));
    check("uni_p1", 128'(response_out_payload), 128'h11);
    step();
    check("uni_v3", 128'(response_out_valid),   128'(4'b1000));
    check("uni_p3", 128'(response_out_payload), 128'h13);
    check("uni_empty_drained", 128'(fifo_empty), 128'(1'b1));
    step();
    check("uni_idle", 128'(response_out_valid), 128'(4'b0000));

    // Broadcast with staggered ready, followed by a unicast head
    response_out_ready = 4'b0000;
    drive(4'hF, 128'hBB); step();
    drive(4'd1, 128'hC1); step();
    idle_in(); step();
    check("bc_v_all", 128'(response_out_valid),   128'(4'b1111));
    check("bc_p",     128'(response_out_payload), 128'hBB);
    response_out_ready = 4'b0001; step();
    check("bc_v_l0", 128'(response_out_valid), 128'(4'b1110));
    response_out_ready = 4'b0000; step();
    check("bc_v_hold", 128'(response_out_valid), 128'(4'b1110));
    response_out_ready = 4'b1110; step();
    check("bc_next_v", 128'(response_out_valid),   128'(4'b0010));
    check("bc_next_p", 128'(response_out_payload), 128'hC1);
    response_out_ready = 4'b1111; step();
    check("bc_done", 128'(response_out_valid), 128'(4'b0000));
    check("bc_drop", 128'(drop_count), 128'(16'h0000));

    // Unroutable destination
    drive(4'd5, 128'h55); step();
    check("unr_v_a", 128'(response_out_valid), 128'(4'b0000));
    idle_in(); step();
    check("unr_v_b", 128'(response_out_valid), 128'(4'b0000));
    step();
    check("unr_v_c", 128'(response_out_valid), 128'(4'b0000));
    check("unr_drop", 128'(drop_count), 128'(16'h0001));
    check("unr_nb_drop", 128'(nb_drop), 128'(16'h0002));
    step();
    check("unr_v_d", 128'(response_out_valid), 128'(4'b0000));
    check("unr_empty", 128'(fifo_empty), 128'(1'b1));

    // Backpressure and overflow: 18 writes, lane 0, no ready
    response_out_ready = 4'b0000;
    for (int i = 0; i < 18; i++) begin
      drive(4'd0, 128'(12'h100 + i));
      step();
      cnt = (i >= 2) ? i - 1 : i;
      check($sformatf("bp_prog_%0d", i), 128'(fifo_prog_full), 128'(cnt >= 12));
      check($sformatf("bp_full_%0d", i), 128'(fifo_full),      128'(cnt == 16));
      check($sformatf("bp_ovf_%0d", i),  128'(fifo_overflow),  128'(1'b0));
    end
    idle_in(); step();
    check("bp_ovf_set", 128'(fifo_overflow), 128'(1'b1));
    check("bp_full_hold", 128'(fifo_full), 128'(1'b1));
    response_out_ready = 4'b0001;
    for (int k = 0; k < 17; k++) begin
      check($sformatf("drain_v_%0d", k), 128'(response_out_valid),   128'(4'b0001));
      check($sformatf("drain_p_%0d", k), 128'(response_out_payload), 128'(12'h100 + k));
      step();
    end
    check("drain_done_v", 128'(response_out_valid), 128'(4'b0000));
    check("drain_empty",  128'(fifo_empty), 128'(1'b1));
    check("drain_ovf_sticky", 128'(fifo_overflow), 128'(1'b1));

    // Reset mid-stream with 8 entries buffered and one held
    response_out_ready = 4'b0000;
    for (int i = 0; i < 9; i++) begin
      drive(4'd1, 128'(12'h200 + i));
      step();
    end
    idle_in(); step();
    check("mid_empty_pre", 128'(fifo_empty), 128'(1'b0));
    check("mid_v_pre", 128'(response_out_valid), 128'(4'b0010));
    areset = 1'b1; step();
    check("mid_v",     128'(response_out_valid),   128'(4'b0000));
    check("mid_p",     128'(response_out_payload), 128'(0));
    check("mid_empty", 128'(fifo_empty),    128'(1'b1));
    check("mid_drop",  128'(drop_count),    128'(16'h0000));
    check("mid_ovf",   128'(fifo_overflow), 128'(1'b0));
    check("mid_setup", 128'(fifo_setup_signal), 128'(1'b1));
    areset = 1'b0;
    response_out_ready = 4'b1111;
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("post_v_%0d", i), 128'(response_out_valid), 128'(4'b0000));
    end
    check("post_empty", 128'(fifo_empty), 128'(1'b1));
    check("post_setup", 128'(fifo_setup_signal), 128'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
